// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage between the EX/MEM register and a
// word-wide data memory. Byte-addressed loads/stores become word accesses.
// Sub-word loads are extracted and extended from the read word. Byte and
// half stores run as a two-cycle read-modify-write (IDLE read, MERGE write)
// and stall upstream during the read cycle.
// Optional feature macro: MISALIGN_TRAP_EN (trap misaligned half/word
// accesses instead of aligning them down).
module mem_access_stage #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32   // only 32 is supported
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_load,
  input  logic              in_store,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [31:0]       in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [4:0]        in_rd,
  input  logic              in_regwrite,
  output logic              stall,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic              wb_regwrite,
  output logic [DATA_W-1:0] wb_data,
  output logic              misalign_err
);

  typedef enum logic {IDLE, MERGE} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] old_q;
  logic              wb_valid_q;
  logic [4:0]        wb_rd_q;
  logic              wb_regwrite_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              err_q;

  logic              is_load;
  logic              is_store;
  logic              size_half;
  logic              size_word;
  logic              sub_store;
  logic              misaligned;
  logic              idle;
  logic [1:0]        lane;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] load_ext;
  logic [DATA_W-1:0] merged;
  logic              unused_addr_hi;

  // Address bits above the memory range only wrap; they are deliberately ignored.
  assign unused_addr_hi = ^in_addr[31:ADDR_W+2];

  // Request decode: store wins over load, nothing happens without in_valid.
  always_comb begin
    is_store  = in_valid & in_store;
    is_load   = in_valid & in_load & ~in_store;
    size_word = in_size[1];
    size_half = (in_size == 2'b01);
    sub_store = is_store & ~size_word;
    idle      = (state_q == IDLE);
  end

`ifdef MISALIGN_TRAP_EN
  // Misaligned half/word accesses are trapped and never reach memory.
  assign misaligned = (is_load | is_store) &
                      ((size_half & in_addr[0]) | (size_word & (in_addr[1:0] != 2'b00)));
`else
  // Misaligned accesses are silently aligned down through the lane select.
  assign misaligned = 1'b0;
`endif

  // Lane offset inside the word, with the offending low bits forced to zero.
  always_comb begin
    lane = in_addr[1:0];
    if (size_word) begin
      lane = 2'b00;
    end else if (size_half) begin
      lane = {in_addr[1], 1'b0};
    end
  end

  // Little-endian lane extraction and sign/zero extension of load data.
  always_comb begin
    byte_sel = mem_dout[{lane, 3'b000} +: 8];
    half_sel = mem_dout[{lane[1], 4'b0000} +: 16];
    if (size_word) begin
      load_ext = mem_dout;
    end else if (size_half) begin
      load_ext = {{16{~in_unsigned & half_sel[15]}}, half_sel};
    end else begin
      load_ext = {{24{~in_unsigned & byte_sel[7]}}, byte_sel};
    end
  end

  // Replace the selected lane of the captured word with the store data.
  always_comb begin
    merged = old_q;
    if (size_half) begin
      merged[{lane[1], 4'b0000} +: 16] = in_wdata[15:0];
    end else begin
      merged[{lane, 3'b000} +: 8] = in_wdata[7:0];
    end
  end

  // Memory strobes follow the held request; reset suppresses every strobe,
  // which also drops a pending MERGE write.
  always_comb begin
    mem_read  = ~reset & idle & ~misaligned & (is_load | sub_store);
    mem_write = ~reset & ((idle & ~misaligned & is_store & size_word) | (~idle & in_valid));
    stall     = ~reset & idle & ~misaligned & sub_store;
    mem_addr  = in_addr[ADDR_W+1:2];
    mem_din   = idle ? in_wdata : merged;
  end

  // RMW state machine and registered MEM/WB slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      old_q         <= '0;
      wb_valid_q    <= 1'b0;
      wb_rd_q       <= 5'd0;
      wb_regwrite_q <= 1'b0;
      wb_data_q     <= '0;
      err_q         <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          wb_rd_q <= in_rd;
          if (misaligned) begin
            wb_valid_q    <= 1'b1;
            wb_regwrite_q <= 1'b0;
            wb_data_q     <= in_addr;
            err_q         <= 1'b1;
          end else if (sub_store) begin
            // Read half of the RMW: the slot stays empty until the write.
            old_q         <= mem_dout;
            state_q       <= MERGE;
            wb_valid_q    <= 1'b0;
            wb_regwrite_q <= 1'b0;
          end else if (is_store) begin
            wb_valid_q    <= 1'b1;
            wb_regwrite_q <= 1'b0;
            wb_data_q     <= in_alu_result;
          end else if (is_load) begin
            wb_valid_q    <= 1'b1;
            wb_regwrite_q <= in_regwrite;
            wb_data_q     <= load_ext;
          end else begin
            wb_valid_q    <= in_valid;
            wb_regwrite_q <= in_regwrite;
            wb_data_q     <= in_alu_result;
          end
        end
        MERGE: begin
          state_q       <= IDLE;
          wb_valid_q    <= 1'b1;
          wb_rd_q       <= in_rd;
          wb_regwrite_q <= 1'b0;
          wb_data_q     <= in_alu_result;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_regwrite  = wb_regwrite_q;
  assign wb_data      = wb_data_q;
  assign misalign_err = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: word memory environment plus a
// byte-array reference model; directed cases then randomized operations.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_load, in_store, in_unsigned, in_regwrite;
  logic [1:0]  in_size;
  logic [31:0] in_addr, in_wdata, in_alu_result;
  logic [4:0]  in_rd;
  logic        stall, mem_read, mem_write;
  logic [9:0]  mem_addr;
  logic [31:0] mem_din, mem_dout;
  logic        wb_valid, wb_regwrite, misalign_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int errors = 0;
  int checks = 0;
  int wr_count = 0;

  logic [31:0] mem_w [1024];
  logic [7:0]  ref_b [4096];

  mem_access_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_load(in_load),
    .in_store(in_store), .in_size(in_size), .in_unsigned(in_unsigned),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_alu_result(in_alu_result),
    .in_rd(in_rd), .in_regwrite(in_regwrite), .stall(stall),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_data(wb_data),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  // Data memory: read sampled on negedge, write on posedge.
  always @(negedge clk) begin
    if (mem_read) mem_dout <= mem_w[mem_addr];
  end
  always @(posedge clk) begin
    if (mem_write) begin
      mem_w[mem_addr] <= mem_din;
      wr_count <= wr_count + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
  endfunction

  // One operation: drive, check strobes, check the MEM/WB result.
  task automatic do_op(input logic v, input logic ld, input logic st, input logic [1:0] sz,
                       input logic un, input logic [31:0] ad, input logic [31:0] wd,
                       input logic [31:0] alu, input logic [4:0] rd, input logic rw);
    logic is_ld, is_st, mis;
    int nb, ea;
    logic [31:0] exp_load;
    in_valid = v; in_load = ld; in_store = st; in_size = sz; in_unsigned = un;
    in_addr = ad; in_wdata = wd; in_alu_result = alu; in_rd = rd; in_regwrite = rw;
    is_st = v & st;
    is_ld = v & ld & ~st;
    nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    ea = int'(ad & 32'hFFF);
    ea = ea - (ea % nb);
`ifdef MISALIGN_TRAP_EN
    mis = (is_ld | is_st) & (((sz == 2'b01) & ad[0]) | (sz[1] & (ad[1:0] != 2'b00)));
`else
    mis = 1'b0;
`endif
    exp_load = 32'd0;
    for (int k = 0; k < nb; k++) exp_load = exp_load | (32'(ref_b[ea+k]) << (8*k));
    if (!un && nb < 4 && exp_load[8*nb-1]) exp_load = exp_load | ~((32'd1 << (8*nb)) - 32'd1);
    #3;
    if (mis) begin
      chk("mis_read", 32'(mem_read), 32'd0);
      chk("mis_write", 32'(mem_write), 32'd0);
      chk("mis_stall", 32'(stall), 32'd0);
    end else if (is_ld) begin
      chk("ld_read", 32'(mem_read), 32'd1);
      chk("ld_write", 32'(mem_write), 32'd0);
      chk("ld_stall", 32'(stall), 32'd0);
      chk("ld_addr", 32'(mem_addr), 32'(ea / 4));
    end else if (is_st && nb == 4) begin
      for (int k = 0; k < 4; k++) ref_b[ea+k] = 8'(wd >> (8*k));
      chk("sw_write", 32'(mem_write), 32'd1);
      chk("sw_read", 32'(mem_read), 32'd0);
      chk("sw_stall", 32'(stall), 32'd0);
      chk("sw_addr", 32'(mem_addr), 32'(ea / 4));
      chk("sw_din", mem_din, wd);
    end else if (is_st) begin
      for (int k = 0; k < nb; k++) ref_b[ea+k] = 8'(wd >> (8*k));
      chk("rmw_read", 32'(mem_read), 32'd1);
      chk("rmw_write0", 32'(mem_write), 32'd0);
      chk("rmw_stall", 32'(stall), 32'd1);
      chk("rmw_raddr", 32'(mem_addr), 32'(ea / 4));
      @(posedge clk); #1;
      chk("rmw_bubble", 32'(wb_valid), 32'd0);
      chk("rmw_stall_off", 32'(stall), 32'd0);
      chk("rmw_write1", 32'(mem_write), 32'd1);
      chk("rmw_read_off", 32'(mem_read), 32'd0);
      chk("rmw_waddr", 32'(mem_addr), 32'(ea / 4));
      chk("rmw_din", mem_din, ref_word(ea / 4));
    end else begin
      chk("nop_read", 32'(mem_read), 32'd0);
      chk("nop_write", 32'(mem_write), 32'd0);
      chk("nop_stall", 32'(stall), 32'd0);
    end
    @(posedge clk); #1;
    chk("wb_valid", 32'(wb_valid), 32'(v));
    chk("wb_rd", 32'(wb_rd), 32'(rd));
    chk("wb_regwrite", 32'(wb_regwrite), (is_st | mis) ? 32'd0 : 32'(rw));
    chk("misalign_err", 32'(misalign_err), 32'(mis));
    if (mis) chk("wb_data_mis", wb_data, ad);
    else if (is_ld) chk("wb_data_ld", wb_data, exp_load);
    else if (!is_st) chk("wb_data_alu", wb_data, alu);
    $display("op v=%0d ld=%0d st=%0d sz=%0d un=%0d addr=%h wd=%h -> wb_data=%h", v, ld, st, sz, un, ad, wd, wb_data);
  endtask

  initial begin
    int cnt;
    logic [31:0] r;
    for (int i = 0; i < 1024; i++) mem_w[i] = 32'h000001FF;
    for (int i = 0; i < 1024; i++) begin
      ref_b[4*i] = 8'hFF; ref_b[4*i+1] = 8'h01; ref_b[4*i+2] = 8'h00; ref_b[4*i+3] = 8'h00;
    end
    mem_dout = 32'd0;
    reset = 1'b1;
    in_valid = 0; in_load = 0; in_store = 0; in_size = 0; in_unsigned = 0;
    in_addr = 0; in_wdata = 0; in_alu_result = 0; in_rd = 0; in_regwrite = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_regwrite", 32'(wb_regwrite), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_err", 32'(misalign_err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_read", 32'(mem_read), 32'd0);
    chk("rst_write", 32'(mem_write), 32'd0);
    reset = 1'b0;

    // Directed cases from the memory preloaded with 0x000001FF.
    do_op(1, 1, 0, 2'b10, 0, 32'h008, 0, 32'h11, 5'd1, 1);
    chk("lw_008", wb_data, 32'h000001FF);
    do_op(1, 1, 0, 2'b00, 0, 32'h005, 0, 32'h22, 5'd2, 1);
    chk("lb_005", wb_data, 32'h00000001);
    do_op(1, 1, 0, 2'b00, 0, 32'h004, 0, 32'h33, 5'd3, 1);
    chk("lb_004", wb_data, 32'hFFFFFFFF);
    do_op(1, 1, 0, 2'b00, 1, 32'h004, 0, 32'h44, 5'd4, 1);
    chk("lbu_004", wb_data, 32'h000000FF);
    do_op(1, 0, 1, 2'b00, 0, 32'h00D, 32'h000000AB, 32'h55, 5'd5, 1);
    chk("sb_00D_mem", mem_w[3], 32'h0000ABFF);
    do_op(1, 1, 0, 2'b10, 0, 32'h00C, 0, 32'h66, 5'd6, 1);
    chk("lw_00C", wb_data, 32'h0000ABFF);
    do_op(1, 0, 1, 2'b01, 0, 32'h012, 32'h00001234, 32'h77, 5'd7, 1);
    do_op(1, 1, 0, 2'b01, 0, 32'h012, 0, 32'h88, 5'd8, 1);
    chk("lh_012", wb_data, 32'h00001234);
    do_op(0, 1, 0, 2'b10, 0, 32'h010, 0, 32'h99, 5'd9, 1);
    do_op(1, 0, 0, 2'b10, 0, 32'h000, 0, 32'hDEADBEEF, 5'd10, 1);

    // Reset while the sb 0x000 write is pending: the write must be dropped.
    in_valid = 1; in_load = 0; in_store = 1; in_size = 2'b00; in_unsigned = 0;
    in_addr = 32'h000; in_wdata = 32'h5A; in_alu_result = 0; in_rd = 5'd11; in_regwrite = 1;
    #3;
    chk("rst_merge_stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    cnt = wr_count;
    reset = 1'b1;
    #1;
    chk("rst_merge_nowrite", 32'(mem_write), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid = 0; in_store = 0;
    #1;
    chk("rst_merge_wrcount", 32'(wr_count), 32'(cnt));
    chk("rst_merge_wbv", 32'(wb_valid), 32'd0);
    chk("rst_merge_write_after", 32'(mem_write), 32'd0);
    @(posedge clk); #1;
    do_op(1, 1, 0, 2'b10, 0, 32'h000, 0, 32'h12, 5'd12, 1);
    chk("lw_000_after_rst", wb_data, 32'h000001FF);
    $display("reset-in-merge: writes=%0d wb_data=%h", wr_count - cnt, wb_data);

`ifdef MISALIGN_TRAP_EN
    do_op(1, 1, 0, 2'b10, 0, 32'h006, 0, 32'h13, 5'd13, 1);
    chk("trap_err", 32'(misalign_err), 32'd1);
    do_op(1, 0, 0, 2'b10, 0, 32'h000, 0, 32'h14, 5'd14, 1);
    chk("trap_err_pulse", 32'(misalign_err), 32'd0);
`endif

    // Randomized operations over a small window with random high address bits.
    for (int i = 0; i < 300; i++) begin
      logic v, ld, st, un, rw;
      logic [1:0] sz;
      int op;
      v  = ($urandom % 8) != 0;
      op = int'($urandom % 3);
      st = (op == 2);
      ld = (op == 1) || (op == 2 && ($urandom % 4) == 0);
      sz = 2'($urandom % 4);
      un = 1'($urandom % 2);
      rw = 1'($urandom % 2);
      r  = $urandom;
      do_op(v, ld, st, sz, un, (r & 32'hFFFFF000) | ($urandom % 64), $urandom, $urandom,
            5'($urandom % 32), rw);
    end

    for (int w = 0; w < 16; w++) chk("final_mem", mem_w[w], ref_word(w));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
